pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Parametrised pipeline control unit: arbitrates several jump/redirect sources, generates a registered redirect to fetch with a valid/busy handshake, and drives per-stage flush and stall vectors.
- Flush can be held for a configurable number of cycles.
- Sits between the execute/commit-side jump sources, the fetch unit (PC/redirect), and the pipeline register stages.

Parameters:
- ADDR_WIDTH, 32, width of jump addresses.
- NUM_SRC, 2, number of jump sources; index 0 is highest priority (oldest instruction).
- NUM_STAGES, 4, number of pipeline register stages; index 0 is the youngest (IF/ID).
- JUMP_STAGE, 2, stage at which jumps resolve; stages [JUMP_STAGE-1:0] are flushed; range 1..NUM_STAGES.
- FLUSH_CYCLES, 1, number of consecutive cycles flush_o stays asserted per accepted jump; must be ≥1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- jump_en_i  input  NUM_SRC  per-source jump request, single-cycle pulse per jump.
- jump_addr_i  input  NUM_SRC*ADDR_WIDTH  per-source target; source i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- stall_req_i  input  NUM_STAGES  per-stage stall request.
- fetch_busy_i  input  1  fetch cannot accept a redirect this cycle.
- jump_en_o  output  1  redirect valid to fetch.
- jump_addr_o  output  ADDR_WIDTH  redirect target.
- flush_o  output  NUM_STAGES  per-stage flush.
- stall_o  output  NUM_STAGES  per-stage stall.
- busy_o  output  1  flush sequence in progress (FLUSH state).

Behaviour:
- Reset (async, rst_n=0): jump_en_o=0, jump_addr_o=0, flush_o=0, busy_o=0, state=IDLE, flush counter=0. stall_o follows its combinational equation.
- Arbitration: the selected source is the lowest index i with jump_en_i[i]=1. It is accepted only when the state is IDLE and no redirect is held (jump_en_o=0, or jump_en_o=1 with fetch_busy_i=0 this cycle).
- Accept (edge N): at edge N+1, jump_en_o=1, jump_addr_o=selected addr, flush_o[k]=1 for k<JUMP_STAGE and 0 otherwise, state→FLUSH, counter=FLUSH_CYCLES-1. Latency is exactly 1 cycle.
- Redirect handshake: the transfer completes on a cycle with jump_en_o=1 and fetch_busy_i=0. jump_en_o clears at the next edge unless a new accept occurs on that same edge. While fetch_busy_i=1, jump_en_o and jump_addr_o are held stable.
- FLUSH state:
  - flush_o holds its mask; busy_o=1.
  - The counter decrements each cycle; at counter=0, return to IDLE at the next edge and clear flush_o.
  - FLUSH_CYCLES=1 gives a single-cycle flush pulse.
- Masking: all jump_en_i are ignored while busy_o=1, since those instructions are being flushed. Jumps arriving while a redirect is still held (fetch_busy_i=1) in IDLE are also ignored. Sources must not issue a jump in that window; an assertion flags it.
- Stall: stall_o[k] = (OR of stall_req_i[j] for j≥k) & ~flush_o[k]. This is combinational, zero latency. An older stall freezes all younger stages; flush overrides stall on the same stage.
- FLUSH exit with a held redirect: if the FLUSH counter expires while the redirect is still held, the state returns to IDLE and jump_en_o remains held until fetch_busy_i=0.
- Reset mid-operation: immediate return to reset values; any held redirect is dropped.

Test Plan:
- Reset then idle, all inputs 0 → jump_en_o=0, flush_o=0000, stall_o=0000, busy_o=0.
- Priority and latency: jump_en_i=2'b11, addr0=0x0000_1000, addr1=0x0000_2000 for one cycle → next cycle jump_en_o=1, jump_addr_o=0x1000, flush_o=0011; the following cycle jump_en_o=0, flush_o=0000.
- Multi-cycle flush: FLUSH_CYCLES=3, pulse jump_en_i[1]=1 with addr 0x80 → flush_o=0011 and busy_o=1 for exactly 3 cycles. A jump_en_i[0] pulse during the 2nd cycle is ignored: no second redirect, no extension.
- Fetch backpressure: fetch_busy_i=1 for 4 cycles after accept of 0x44 → jump_en_o=1 and jump_addr_o=0x44 stable for 5 cycles, dropping one edge after fetch_busy_i falls. flush_o still lasts FLUSH_CYCLES only.
- Stall propagation: stall_req_i=0100, no flush → stall_o=0111. Same cycle with flush_o=0011 → stall_o=0100.
- Async reset asserted during FLUSH with a held redirect → all outputs 0 immediately, without waiting for a clock edge. After release, a new jump is accepted normally.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: arbitrates jump sources into a single registered fetch
// redirect, sequences a multi-cycle flush of the younger stages and derives stalls.
module pipe_ctrl_unit #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned NUM_STAGES    = 4,
    parameter int unsigned JUMP_STAGE    = 2,
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter bit          JUMP_CHECK_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            jump_en_i,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] jump_addr_i,
    input  logic [NUM_STAGES-1:0]         stall_req_i,
    input  logic                          fetch_busy_i,
    output logic                          jump_en_o,
    output logic [ADDR_WIDTH-1:0]         jump_addr_o,
    output logic [NUM_STAGES-1:0]         flush_o,
    output logic [NUM_STAGES-1:0]         stall_o,
    output logic                          busy_o
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
    // Stages older than the resolving stage survive; everything younger is flushed.
    localparam logic [NUM_STAGES-1:0] FLUSH_MASK =
        {NUM_STAGES{1'b1}} >> (NUM_STAGES - JUMP_STAGE);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    jump_en_q, jump_en_d;
    logic [ADDR_WIDTH-1:0]   jump_addr_q, jump_addr_d;
    logic [NUM_STAGES-1:0]   flush_q, flush_d;
    logic                    busy_q, busy_d;

    logic                    sel_valid;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    xfer_done;
    logic                    accept;
    logic                    older_stall;

    // Lowest index wins: iterate downwards so the last hit is the oldest source.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (jump_en_i[i]) begin
                sel_valid = 1'b1;
                sel_addr  = jump_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign xfer_done = jump_en_q & ~fetch_busy_i;
    assign accept    = (state_q == ST_IDLE) & (~jump_en_q | ~fetch_busy_i) & sel_valid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        jump_en_d   = jump_en_q;
        jump_addr_d = jump_addr_q;
        flush_d     = flush_q;

        if (xfer_done) begin
            jump_en_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    jump_en_d   = 1'b1;
                    jump_addr_d = sel_addr;
                    flush_d     = FLUSH_MASK;
                    cnt_d       = CNT_INIT;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // A still-held redirect survives the exit; only the flush ends.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    flush_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                flush_d = '0;
            end
        endcase

        busy_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            jump_en_q   <= 1'b0;
            jump_addr_q <= '0;
            flush_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            jump_en_q   <= jump_en_d;
            jump_addr_q <= jump_addr_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
        end
    end

    // An older stall freezes every younger stage; a flush of the stage wins.
    always_comb begin
        older_stall = 1'b0;
        stall_o     = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            older_stall = older_stall | stall_req_i[k];
            stall_o[k]  = older_stall & ~flush_q[k];
        end
    end

    assign jump_en_o   = jump_en_q;
    assign jump_addr_o = jump_addr_q;
    assign flush_o     = flush_q;
    assign busy_o      = busy_q;

    assert property (@(posedge clk) disable iff (!rst_n || !JUMP_CHECK_EN)
        !((|jump_en_i) && (busy_q || (jump_en_q && fetch_busy_i))))
        else $error("pipe_ctrl_unit: jump request while sources are masked");

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench: two instances (1- and 3-cycle flush) share stimulus and are
// compared each cycle against a behavioural model; redirects are scored on transfer.
module tb_pipe_ctrl_unit;

    localparam int AW  = 32;
    localparam int NS  = 2;
    localparam int NST = 4;
    localparam int JS  = 2;

    logic              clk;
    logic              rst_n;
    logic [NS-1:0]     jump_en_i;
    logic [NS*AW-1:0]  jump_addr_i;
    logic [NST-1:0]    stall_req_i;
    logic              fetch_busy_i;

    logic [1:0]        jen_o;
    logic [AW-1:0]     addr_o  [2];
    logic [NST-1:0]    flush_o [2];
    logic [NST-1:0]    stall_o [2];
    logic [1:0]        busy_o;

    int errors = 0;
    int checks = 0;

    // Model state per instance: held redirect and remaining flush cycles.
    bit            m_held [2];
    logic [AW-1:0] m_addr [2];
    int            m_left [2];
    logic [AW-1:0] sb_q0 [$];
    logic [AW-1:0] sb_q1 [$];

    pipe_ctrl_unit #(.ADDR_WIDTH(AW), .NUM_SRC(NS), .NUM_STAGES(NST), .JUMP_STAGE(JS),
                     .FLUSH_CYCLES(1), .JUMP_CHECK_EN(1'b0)) u_fc1 (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .stall_req_i(stall_req_i), .fetch_busy_i(fetch_busy_i),
        .jump_en_o(jen_o[0]), .jump_addr_o(addr_o[0]), .flush_o(flush_o[0]),
        .stall_o(stall_o[0]), .busy_o(busy_o[0]));

    pipe_ctrl_unit #(.ADDR_WIDTH(AW), .NUM_SRC(NS), .NUM_STAGES(NST), .JUMP_STAGE(JS),
                     .FLUSH_CYCLES(3), .JUMP_CHECK_EN(1'b0)) u_fc3 (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .stall_req_i(stall_req_i), .fetch_busy_i(fetch_busy_i),
        .jump_en_o(jen_o[1]), .jump_addr_o(addr_o[1]), .flush_o(flush_o[1]),
        .stall_o(stall_o[1]), .busy_o(busy_o[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fc_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [NST-1:0] exp_flush(input int d);
        return (m_left[d] > 0) ? 4'b0011 : 4'b0000;
    endfunction

    function automatic logic [NST-1:0] exp_stall(input logic [NST-1:0] req,
                                                 input logic [NST-1:0] fl);
        logic [NST-1:0] r;
        r = '0;
        for (int k = 0; k < NST; k++)
            r[k] = ((req >> k) != 0) && !fl[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_held[d] = 1'b0;
            m_addr[d] = '0;
            m_left[d] = 0;
        end
        sb_q0.delete();
        sb_q1.delete();
    endtask

    // Next-state of the model from the inputs seen at this clock edge.
    task automatic model_step();
        logic [AW-1:0] sel;
        bit            can;
        sel = jump_en_i[0] ? jump_addr_i[AW-1:0] : jump_addr_i[2*AW-1:AW];
        for (int d = 0; d < 2; d++) begin
            can = (m_left[d] == 0) && (!m_held[d] || !fetch_busy_i);
            if (can && jump_en_i != 0) begin
                m_held[d] = 1'b1;
                m_addr[d] = sel;
                m_left[d] = fc_of(d);
                if (d == 0) sb_q0.push_back(sel);
                else        sb_q1.push_back(sel);
            end else begin
                if (m_held[d] && !fetch_busy_i) m_held[d] = 1'b0;
                if (m_left[d] > 0) m_left[d]--;
            end
        end
    endtask

    task automatic cyc(input logic [1:0] jen, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [NST-1:0] sreq, input logic fb);
        jump_en_i    = jen;
        jump_addr_i  = {a1, a0};
        stall_req_i  = sreq;
        fetch_busy_i = fb;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, '0, '0, '0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_jen"},   jen_o[d],   1'b0);
            chk({tag, "_addr"},  addr_o[d],  '0);
            chk({tag, "_flush"}, flush_o[d], '0);
            chk({tag, "_busy"},  busy_o[d],  1'b0);
        end
    endtask

    // Monitor: compares the model every cycle and scores redirects on transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("jen%0d", d), jen_o[d], m_held[d]);
                chk($sformatf("flush%0d", d), flush_o[d], exp_flush(d));
                chk($sformatf("busy%0d", d), busy_o[d], m_left[d] > 0);
                chk($sformatf("stall%0d", d), stall_o[d], exp_stall(stall_req_i, exp_flush(d)));
                if (m_held[d]) chk($sformatf("hold_addr%0d", d), addr_o[d], m_addr[d]);
                if (jen_o[d] && !fetch_busy_i) begin
                    if ((d == 0 && sb_q0.size() == 0) || (d == 1 && sb_q1.size() == 0)) begin
                        chk($sformatf("sb_unexpected%0d", d), 1'b1, 1'b0);
                    end else if (d == 0) begin
                        chk("sb_addr0", addr_o[0], sb_q0.pop_front());
                    end else begin
                        chk("sb_addr1", addr_o[1], sb_q1.pop_front());
                    end
                end
            end
        end
    end

    int cnt_busy;
    int cnt_jen;

    initial begin
        rst_n        = 1'b0;
        jump_en_i    = '0;
        jump_addr_i  = '0;
        stall_req_i  = '0;
        fetch_busy_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_stall", stall_o[1], 4'b0000);
        rst_n = 1'b1;
        idle(2);

        // Priority and one-cycle latency
        cyc(2'b11, 32'h0000_1000, 32'h0000_2000, '0, 1'b0);
        chk("prio_jen",   jen_o[0],   1'b1);
        chk("prio_addr",  addr_o[0],  32'h0000_1000);
        chk("prio_flush", flush_o[0], 4'b0011);
        cyc(2'b00, '0, '0, '0, 1'b0);
        chk("prio_jen_off",   jen_o[0],   1'b0);
        chk("prio_flush_off", flush_o[0], 4'b0000);
        idle(4);

        // Multi-cycle flush, a jump in its second cycle is ignored by the 3-cycle unit
        cnt_busy = 0;
        cnt_jen  = 0;
        cyc(2'b10, '0, 32'h80, '0, 1'b0);
        cnt_busy += busy_o[1];
        cnt_jen  += jen_o[1];
        cyc(2'b01, 32'h999, '0, '0, 1'b0);
        cnt_busy += busy_o[1];
        cnt_jen  += jen_o[1];
        for (int i = 0; i < 5; i++) begin
            cyc(2'b00, '0, '0, '0, 1'b0);
            cnt_busy += busy_o[1];
            cnt_jen  += jen_o[1];
        end
        chk("mflush_busy_cycles", cnt_busy, 3);
        chk("mflush_redirects",   cnt_jen,  1);
        idle(4);

        // Fetch backpressure
        cnt_busy = 0;
        cnt_jen  = 0;
        cyc(2'b01, 32'h44, '0, '0, 1'b0);
        cnt_busy += busy_o[1];
        cnt_jen  += jen_o[1];
        for (int i = 0; i < 4; i++) begin
            cyc(2'b00, '0, '0, '0, 1'b1);
            cnt_busy += busy_o[1];
            cnt_jen  += jen_o[1];
            chk("bp_addr", addr_o[1], 32'h44);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, '0, '0, '0, 1'b0);
            cnt_busy += busy_o[1];
            cnt_jen  += jen_o[1];
        end
        chk("bp_jen_cycles",   cnt_jen,  5);
        chk("bp_flush_cycles", cnt_busy, 3);
        idle(4);

        // Stall propagation with and without a flush
        cyc(2'b00, '0, '0, 4'b0100, 1'b0);
        chk("stall_noflush", stall_o[1], 4'b0111);
        cyc(2'b01, 32'h123, '0, 4'b0100, 1'b0);
        chk("stall_flush", stall_o[1], 4'b0100);
        idle(5);

        // Async reset during FLUSH with a held redirect
        cyc(2'b01, 32'h55, '0, '0, 1'b0);
        cyc(2'b00, '0, '0, '0, 1'b1);
        chk("pre_rst_busy", busy_o[1], 1'b1);
        chk("pre_rst_jen",  jen_o[1],  1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        fetch_busy_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(2'b01, 32'h66, '0, '0, 1'b0);
        chk("post_rst_jen",  jen_o[1],  1'b1);
        chk("post_rst_addr", addr_o[1], 32'h66);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
                $urandom, $urandom, 4'($urandom),
                ($urandom_range(0, 3) == 0));
        end
        idle(8);
        chk("sb_drained0", sb_q0.size(), 0);
        chk("sb_drained1", sb_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
